// File: rtl/uart_tx_dev_if.sv
// Bridge-side register bus for the UART transmitter: word address, write strobe,
// write data and combinational read data.
interface uart_tx_dev_if;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;

    modport master (output Addr, WE, Din, input Dout);
    modport slave  (input Addr, WE, Din, output Dout);
endinterface

// File: rtl/uart_tx_dev.sv
// 8N1 UART transmitter on the bridge bus: CPU stores fill a small TX FIFO,
// a four-state FSM serialises bytes LSB first at DIVISOR clocks per bit.
module uart_tx_dev #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_dev_if.slave   bus,
    output logic           IRQ,
    output logic           txd
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic [1:0]         ctrl_q, ctrl_d;
    logic [15:0]        div_q, div_d;
    logic               ovf_q, ovf_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               irq_q, irq_d;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic [1:0]         addr;
    logic               empty, full, push_req, push, pop, bit_end;
    logic [15:0]        div_eff, div_load;
    logic               unused_bits;

    assign addr        = bus.Addr[1:0];
    assign unused_bits = ^{bus.Addr[29:2], bus.Din[31:16]};
    assign div_eff     = (div_q < 16'd2) ? 16'd2 : div_q;
    // The bit counter runs down from DIV-1, so a divisor change only lands at a bit boundary.
    assign div_load    = div_eff - 16'd1;
    assign bit_end     = (cnt_q == 16'd0);
    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_W'(FIFO_DEPTH));
    assign push_req    = bus.WE && (addr == 2'd0);
    assign pop         = ctrl_q[0] && !empty &&
                         ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));
    assign push        = push_req && (!full || pop);
    assign IRQ         = irq_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ctrl_q  <= '0;
            div_q   <= DIV_RESET;
            ovf_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ctrl_q  <= ctrl_d;
            div_q   <= div_d;
            ovf_q   <= ovf_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            irq_q   <= irq_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= bus.Din[7:0];
        end
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        div_d   = div_q;
        ovf_d   = ovf_q;
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push_req && full && !pop) begin
            ovf_d = 1'b1;
        end
        if (bus.WE) begin
            case (addr)
                2'd1:    ctrl_d = bus.Din[1:0];
                2'd2:    ovf_d  = 1'b0;
                2'd3:    div_d  = bus.Din[15:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? div_load : cnt_q - 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = cnt_q;
                if (pop) begin
                    state_d = S_START;
                    cnt_d   = div_load;
                    shift_d = mem_q[rptr_q];
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                // Chaining straight into START keeps back-to-back frames gapless.
                if (bit_end) begin
                    if (pop) begin
                        state_d = S_START;
                        shift_d = mem_q[rptr_q];
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (state_q)
            S_START: txd = 1'b0;
            S_DATA:  txd = shift_q[0];
            default: txd = 1'b1;
        endcase
        irq_d = ctrl_q[1] && empty && (state_q == S_IDLE);
    end

    always_comb begin
        case (addr)
            2'd1:    bus.Dout = {30'd0, ctrl_q};
            2'd2:    bus.Dout = {24'd0, 4'(count_q), ovf_q, (state_q != S_IDLE), full, empty};
            2'd3:    bus.Dout = {16'd0, div_q};
            default: bus.Dout = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_dev.sv
// Scoreboard bench for uart_tx_dev: bytes are queued as they are written and a
// serial-line monitor decodes each frame and checks it against the queue.
module tb_uart_tx_dev;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic IRQ, txd;

    uart_tx_dev_if bus ();

    uart_tx_dev #(.FIFO_DEPTH(8), .DIV_RESET(16'd434)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .IRQ   (IRQ),
        .txd   (txd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_total = 0;
    int         n_bad = 0;
    logic [7:0] sb_q[$];
    int         start_q[$];
    bit         mon_en = 1'b0;
    bit         mon_busy = 1'b0;
    int         mon_div = 4;
    int         wr_cyc = 0;
    logic       mon_prev = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.Addr = {28'd0, a};
        bus.Din  = d;
        bus.WE   = 1'b1;
        wr_cyc   = cyc;
        @(negedge clk);
        bus.WE   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.Addr = {28'd0, a};
        #1;
        d = bus.Dout;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
        #1;
    endtask

    task automatic wait_start(output int s);
        s = -1;
        for (int i = 0; i < 2000 && start_q.size() == 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("frame_started", (start_q.size() > 0), 1);
        if (start_q.size() > 0) s = start_q.pop_front();
    endtask

    task automatic wait_idle();
        logic [31:0] st;
        for (int i = 0; i < 5000; i++) begin
            rd(2'd2, st);
            if (sb_q.size() == 0 && !mon_busy && st[2] == 1'b0) break;
            @(negedge clk);
            #1;
        end
        chk("drained", sb_q.size(), 0);
        start_q.delete();
    endtask

    // Serial monitor: samples every cycle of a frame so bit lengths are checked too.
    initial begin : monitor
        logic [9:0] fb;
        logic       stable, s;
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (mon_en && mon_prev === 1'b1 && txd === 1'b0) begin
                mon_busy = 1'b1;
                start_q.push_back(cyc);
                stable = 1'b1;
                s = txd;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < mon_div; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        s = txd;
                        if (c == 0) fb[b] = s;
                        else if (s !== fb[b]) stable = 1'b0;
                    end
                end
                chk("bit_stable", stable, 1);
                chk("start_bit", fb[0], 0);
                chk("stop_bit", fb[9], 1);
                chk("sb_pending", (sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    exp_b = sb_q.pop_front();
                    chk("frame_byte", fb[8:1], exp_b);
                    $display("frame byte=0x%02h expected=0x%02h", fb[8:1], exp_b);
                end
                mon_prev = s;
                mon_busy = 1'b0;
            end else begin
                mon_prev = txd;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] d;
        int          s, s1, s2, found;
        logic        saw_low;
        bus.Addr = '0;
        bus.Din  = '0;
        bus.WE   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_irq", IRQ, 0);
        reset = 1'b1;
        rd(2'd2, d); chk("rst_status", d, 32'h1);
        rd(2'd3, d); chk("rst_div", d, 32'd434);
        rd(2'd1, d); chk("rst_ctrl", d, 32'd0);

        // Single byte
        mon_div = 4;
        mon_en  = 1'b1;
        wr(2'd3, 32'd4);
        wr(2'd1, 32'd1);
        sb_q.push_back(8'hA5);
        wr(2'd0, 32'hA5);
        rd(2'd0, d); chk("data_reads0", d, 32'd0);
        s1 = wr_cyc;
        wait_start(s);
        chk("latency", s - s1, 2);
        wait_cyc(s + 39); rd(2'd2, d); chk("busy_last", d[2], 1);
        wait_cyc(s + 40); rd(2'd2, d); chk("busy_after40", d[2], 0);
        wait_idle();

        // Back-to-back
        mon_div = 2;
        wr(2'd1, 32'd0);
        wr(2'd3, 32'd2);
        sb_q.push_back(8'h00); wr(2'd0, 32'h00);
        sb_q.push_back(8'hFF); wr(2'd0, 32'hFF);
        rd(2'd2, d); chk("b2b_count2", d[7:4], 2);
        wr(2'd1, 32'd1);
        wait_start(s1);
        rd(2'd2, d); chk("b2b_count1", d[7:4], 1);
        wait_cyc(s1 + 19); rd(2'd2, d); chk("b2b_count1_end", d[7:4], 1);
        wait_cyc(s1 + 20); rd(2'd2, d); chk("b2b_count0", d[7:4], 0);
        wait_start(s2);
        chk("b2b_gap", s2 - s1, 20);
        wait_cyc(s1 + 39); rd(2'd2, d); chk("b2b_busy39", d[2], 1);
        wait_cyc(s1 + 40); rd(2'd2, d); chk("b2b_busy40", d[2], 0);
        wait_idle();

        // Overflow
        wr(2'd1, 32'd0);
        for (int v = 1; v <= 9; v++) begin
            if (v <= 8) sb_q.push_back(8'(v));
            wr(2'd0, 32'(v));
        end
        rd(2'd2, d); chk("ovf_status", d, 32'h8A);
        wr(2'd2, 32'd0);
        rd(2'd2, d); chk("ovf_cleared", d, 32'h82);
        wr(2'd1, 32'd1);
        wait_idle();
        rd(2'd2, d); chk("ovf_drained", d, 32'h1);

        // IRQ
        wr(2'd3, 32'd2);
        wr(2'd1, 32'd3);
        @(negedge clk); #1;
        chk("irq_idle", IRQ, 1);
        sb_q.push_back(8'h55);
        wr(2'd0, 32'h55);
        wait_start(s);
        wait_cyc(s + 5);  chk("irq_busy", IRQ, 0);
        wait_cyc(s + 20); chk("irq_idle_first", IRQ, 0);
        wait_cyc(s + 21); chk("irq_rise", IRQ, 1);
        wait_idle();
        wr(2'd1, 32'd1);
        @(negedge clk); #1;
        chk("irq_disabled", IRQ, 0);

        // Reset mid-frame
        mon_en = 1'b0;
        wr(2'd3, 32'd8);
        wr(2'd0, 32'h3C);
        found = 0;
        s = cyc;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk); #1;
            if (txd === 1'b0) begin
                found = 1;
                s = cyc;
            end
        end
        chk("mf_started", found, 1);
        wait_cyc(s + 30);
        rd(2'd2, d); chk("mf_busy", d[2], 1);
        reset = 1'b0;
        #1;
        chk("mf_rst_txd", txd, 1);
        rd(2'd2, d); chk("mf_rst_status", d, 32'h1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rd(2'd1, d); chk("mf_ctrl", d, 32'd0);
        rd(2'd3, d); chk("mf_div", d, 32'd434);
        saw_low = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) saw_low = 1'b1;
        end
        chk("mf_no_resume", saw_low, 0);
        rd(2'd2, d); chk("mf_status_after", d, 32'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
